// File: rtl/pll_rst_pkg.sv
// Shared types and 16 MHz default timing for the PLL reset sequencer.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    RST_PLL   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int PLLRST_CYCLES = 16;      // 1 us
  localparam int STABLE_CYCLES = 1600;    // 100 us
  localparam int LOCK_TIMEOUT  = 160000;  // 10 ms

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous status bit, async active-high clear.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) sr <= '0;
    else     sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses PLL RST, qualifies lock, then releases the 12 MHz system reset.
// Optional macro PLL_RST_SEQ_RELOCK_CNT_EN keeps the relock_count register; otherwise it reads 0.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int PLLRST_CYCLES = pll_rst_pkg::PLLRST_CYCLES,
  parameter int STABLE_CYCLES = pll_rst_pkg::STABLE_CYCLES,
  parameter int LOCK_TIMEOUT  = pll_rst_pkg::LOCK_TIMEOUT,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             sys_ready,
  output logic             lock_lost,
  output logic [CNT_W-1:0] relock_count
);

  // One counter is shared by all states; it restarts on every transition,
  // so its width only needs to cover the largest limit.
  localparam int CW = $clog2(max3(PLLRST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT));

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            locked_s;
  logic            relock_inc;
  logic            lost_nxt;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .clr (rst),
    .d   (pll_locked),
    .q   (locked_s)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = '0;
    relock_inc = 1'b0;
    lost_nxt   = 1'b0;
    unique case (state)
      RST_PLL: begin
        if (cnt == CW'(PLLRST_CYCLES - 1)) state_nxt = WAIT_LOCK;
        else                               cnt_nxt   = cnt + 1'b1;
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_nxt = STABLE;
        end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
          state_nxt  = RST_PLL;
          relock_inc = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      STABLE: begin
        if (!locked_s)                          state_nxt = WAIT_LOCK;
        else if (cnt == CW'(STABLE_CYCLES - 1)) state_nxt = RUN;
        else                                    cnt_nxt   = cnt + 1'b1;
      end
      RUN: begin
        if (!locked_s) begin
          state_nxt  = RST_PLL;
          relock_inc = 1'b1;
          lost_nxt   = 1'b1;
        end
      end
      default: state_nxt = RST_PLL;
    endcase
  end

  // Outputs decode the next state so they move on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RST_PLL;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      sys_ready <= 1'b0;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      pll_rst   <= (state_nxt == RST_PLL);
      sys_rst   <= (state_nxt != RUN);
      sys_ready <= (state_nxt == RUN);
      lock_lost <= lost_nxt;
    end
  end

`ifdef PLL_RST_SEQ_RELOCK_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  relock_count <= '0;
    else if (relock_inc && relock_count != '1) relock_count <= relock_count + 1'b1;
  end
`else
  logic relock_unused;
  assign relock_unused = relock_inc;
  assign relock_count  = '0;
`endif

endmodule

// File: doc/pll_rst_seq.md
Name: pll_rst_seq

Overview:
- Reset sequencer sitting directly downstream of the 16→12 MHz PLL.
- Clocked by the free-running 16 MHz board clock (the PLL's input), so it keeps running while the PLL is held in reset or unlocked.
- Consumes the PLL `locked` flag and drives the PLL `RST` pin.
- Produces the system reset and ready flag for the 12 MHz domain. It releases them only after lock has been continuously stable, and re-runs the PLL reset on lock timeout or lock loss.

Parameters:
- SYNC_STAGES, 2, flops in the pll_locked synchroniser (min 2).
- PLLRST_CYCLES, 16, clk cycles pll_rst is held high per attempt (min 1).
- STABLE_CYCLES, 1600, consecutive synchronised-locked cycles required before release (100 us at 16 MHz, min 1).
- LOCK_TIMEOUT, 160000, clk cycles allowed in WAIT_LOCK before a new PLL reset (10 ms, min 2).
- CNT_W, 8, width of relock_count.

Ports:
- clk  in  1  free-running 16 MHz reference clock.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL LOCK, asynchronous to clk.
- pll_rst  out  1  to PLL RST, registered.
- sys_rst  out  1  system reset for the 12 MHz domain. Registered; the consumer re-synchronises deassertion.
- sys_ready  out  1  high while in RUN, registered.
- lock_lost  out  1  one-cycle pulse when lock drops in RUN.
- relock_count  out  CNT_W  saturating count of PLL reset attempts after the first.

Behaviour:
- Async reset (rst=1):
  - state = RST_PLL; all counters 0; synchroniser flops 0.
  - pll_rst=1, sys_rst=1, sys_ready=0, lock_lost=0, relock_count=0.
- locked_s is pll_locked after SYNC_STAGES flops; all decisions use locked_s only.
- Registered outputs are a decode of the next state, so each output changes on the same edge as the state.
- RST_PLL:
  - Outputs: pll_rst=1, sys_rst=1, sys_ready=0.
  - Counter counts to PLLRST_CYCLES-1, then the state goes to WAIT_LOCK and pll_rst falls. pll_rst is therefore high for exactly PLLRST_CYCLES cycles.
- WAIT_LOCK:
  - Outputs: pll_rst=0, sys_rst=1. The timeout counter starts at 0 on entry.
  - If locked_s=1, go to STABLE with the stable counter at 0.
  - Else if the timeout counter = LOCK_TIMEOUT-1, go to RST_PLL and increment relock_count.
  - If both conditions hold in the same cycle, lock wins.
- STABLE:
  - Outputs: sys_rst=1.
  - If locked_s=0, go to WAIT_LOCK (timeout restarts at 0; not counted as a relock).
  - Else if the stable counter = STABLE_CYCLES-1, go to RUN.
- RUN:
  - Outputs: sys_rst=0, sys_ready=1.
  - If locked_s=0, go to RST_PLL, with lock_lost=1 for exactly that one cycle and relock_count incremented.
  - sys_rst rises and sys_ready falls on the same edge.
- Latency: from the first clk edge sampling pll_locked=1 (held) to sys_rst falling = SYNC_STAGES + STABLE_CYCLES + 1 edges.
- Glitches on pll_locked shorter than one clk period may be missed; glitches of one or more cycles in STABLE restart qualification.
- relock_count saturates at 2^CNT_W-1 and never wraps.
- Counter widths are $clog2 of their respective limits; no counter may overflow for any legal parameter value.
- Mid-operation rst returns to the reset state asynchronously from any state; sys_rst asserts immediately (asynchronous assertion).

Optional Feature:
- PLL_RST_SEQ_RELOCK_CNT_EN defined: relock_count behaves as specified.
- Not defined: relock_count is tied to 0 and its register is removed. All other behaviour is identical.

Decomposition:
- Shared package pll_rst_pkg holds:
  - state enum (RST_PLL, WAIT_LOCK, STABLE, RUN) with 2-bit encoding;
  - default timing constants for the 16 MHz reference (PLLRST_CYCLES, STABLE_CYCLES, LOCK_TIMEOUT).
- One natural sub-module: sync_bit, a SYNC_STAGES-deep flop chain with async active-high clear. It is reused elsewhere for other async status inputs.

Test Plan (SYNC_STAGES=2, PLLRST_CYCLES=4, STABLE_CYCLES=8, LOCK_TIMEOUT=32, macro defined):
- Release rst, raise pll_locked 2 cycles after pll_rst falls → pll_rst high exactly 4 cycles; sys_rst falls 11 edges after locked is first sampled; sys_ready=1 on the same edge; relock_count=0.
- Hold pll_locked=0 → pll_rst re-pulses every 36 cycles (4+32); relock_count reads 1, 2, 3…; sys_rst stays 1.
- In STABLE, drop pll_locked for 1 cycle at stable count 5 → no release; qualification restarts and release occurs 8 cycles after lock returns (+ sync); relock_count unchanged.
- In RUN, drop pll_locked → lock_lost single-cycle pulse; sys_rst=1, sys_ready=0, pll_rst=1 on the same edge; relock_count +1.
- With CNT_W=2, force 5 timeouts → relock_count saturates at 3.
- Assert rst during RUN between clk edges → sys_rst=1, pll_rst=1 immediately (no clock edge), sys_ready=0; after release the sequence restarts from RST_PLL.
